mul_issue_ctrl: RTL and testbench

//  RV32M multiply front end. Sits directly upstream of booth_wallace_multiplier_seq.

---
 rtl/mul_issue_ctrl.sv | 149 ++++++++++++++
 tb/tb_mul_issue_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_ctrl.sv
// RV32M multiply front end: issues one signed 32x32 multiply per request, waits for the
// multiplier's result, applies the unsigned-operand correction and returns the selected word.
module mul_issue_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned RD_W    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [31:0]     req_rs1,
  input  logic [31:0]     req_rs2,
  input  logic [RD_W-1:0] req_rd,
  output logic            mul_en,
  output logic [31:0]     mul_a,
  output logic [31:0]     mul_b,
  input  logic [63:0]     mul_p,
  input  logic            mul_valid,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_data,
  output logic [RD_W-1:0] rsp_rd,
  output logic            rsp_err,
  output logic            busy
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FIX,
    S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic [31:0]     rs1_q, rs1_d;
  logic [31:0]     rs2_q, rs2_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic [63:0]     p_q, p_d;
  logic [31:0]     data_q, data_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [31:0]     hi, corr_a, corr_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      f3_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      p_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      p_q     <= p_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    p_d     = p_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    hi      = p_q[63:32];
    corr_a  = rs2_q[31] ? rs1_q : '0;
    corr_b  = rs1_q[31] ? rs2_q : '0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          f3_d  = req_funct3;
          rs1_d = req_rs1;
          rs2_d = req_rs2;
          rd_d  = req_rd;
          cnt_d = '0;
          if (req_funct3[2]) begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_ISSUE;
          end
        end
      end
      // mul_valid is deliberately not looked at here: it may still be high from the previous op
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mul_valid) begin
          p_d     = mul_p;
          state_d = S_FIX;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FIX: begin
        case (f3_q[1:0])
          2'b00:   data_d = p_q[31:0];
          2'b01:   data_d = hi;
          2'b10:   data_d = hi + corr_a;
          default: data_d = hi + corr_a + corr_b;
        endcase
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign req_ready = (state_q == S_IDLE);
  assign mul_en    = (state_q == S_ISSUE);
  assign mul_a     = busy ? rs1_q : '0;
  assign mul_b     = busy ? rs2_q : '0;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_valid ? data_q : '0;
  assign rsp_rd    = rsp_valid ? rd_q : '0;
  assign rsp_err   = rsp_valid ? err_q : 1'b0;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Scoreboard bench for mul_issue_ctrl with a behavioural multiplier of variable latency.
module tb_mul_issue_ctrl;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned RD_W    = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [2:0]      req_funct3 = '0;
  logic [31:0]     req_rs1 = '0;
  logic [31:0]     req_rs2 = '0;
  logic [RD_W-1:0] req_rd = '0;
  logic            mul_en;
  logic [31:0]     mul_a, mul_b;
  logic [63:0]     mul_p = '0;
  logic            mul_valid = 1'b0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [31:0]     rsp_data;
  logic [RD_W-1:0] rsp_rd;
  logic            rsp_err;
  logic            busy;

  always #5 clk = ~clk;

  mul_issue_ctrl #(.TIMEOUT(TIMEOUT), .RD_W(RD_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .mul_valid(mul_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_err(rsp_err), .busy(busy)
  );

  typedef struct {
    logic [31:0]     data;
    logic [RD_W-1:0] rd;
    logic            err;
    int              lat;
    int              acc;
    logic [31:0]     a;
    logic [31:0]     b;
    int              en;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   req_lat = 2, req_mode = 0;   // multiplier behaviour for the request being driven
  int   cur_lat = 2, cur_mode = 0;   // behaviour for the op currently in flight
  int   rdy_mode = 1;                // 0 random, 1 always ready, 2 never ready
  int   en_cnt = 0;
  int   last_rsp_cyc = -100;
  bit   inflight = 0, seen = 0, b2b_arm = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Architectural result from the RV32M definitions, via 64-bit extended products.
  function automatic logic [31:0] ref_mul(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sxb, ua, ub, pr;
    sa  = {{32{a[31]}}, a};
    sxb = {{32{b[31]}}, b};
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    case (f)
      3'd0:    begin pr = sa * sxb; return pr[31:0]; end
      3'd1:    pr = sa * sxb;
      3'd2:    pr = sa * ub;
      default: pr = ua * ub;
    endcase
    return pr[63:32];
  endfunction

  // Multiplier model: result after cur_lat cycles; mode 0 pulses valid, 1 holds it until the next start, 2 never answers.
  logic [63:0] prod_c, mpend = '0;
  int          mcnt = 0;
  bit          mhold = 0;
  assign prod_c = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};

  always @(posedge clk) begin
    if (mul_en) begin
      mpend     <= prod_c;
      mhold     <= (cur_mode == 1);
      mul_valid <= 1'b0;
      mcnt      <= 0;
      if (cur_mode != 2) begin
        if (cur_lat == 1) begin
          mul_valid <= 1'b1;
          mul_p     <= prod_c;
        end else begin
          mcnt <= cur_lat - 1;
        end
      end
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        mul_valid <= 1'b1;
        mul_p     <= mpend;
      end
    end else if (mul_valid && !mhold) begin
      mul_valid <= 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    rsp_ready = (rdy_mode == 0) ? ($urandom % 4 != 0) : (rdy_mode == 1);
  end

  // Monitor: pushes the expected response on request handshake, checks it when the DUT presents it.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      inflight = 0;
      seen     = 0;
      en_cnt   = 0;
    end else begin
      chk("req_ready", req_ready, !inflight);
      chk("busy", busy, inflight);
      if (mul_en) begin
        en_cnt++;
        if (sb.size() > 0) begin
          chk("mul_a", mul_a, sb[0].a);
          chk("mul_b", mul_b, sb[0].b);
        end
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response (cycle %0d)", cyc);
        end else begin
          if (!seen) begin
            chk("latency", cyc - sb[0].acc, sb[0].lat);
            seen = 1;
          end
          chk("rsp_data", rsp_data, sb[0].data);
          chk("rsp_rd", rsp_rd, sb[0].rd);
          chk("rsp_err", rsp_err, sb[0].err);
          if (rsp_ready) begin
            chk("mul_en_count", en_cnt, sb[0].en);
            void'(sb.pop_front());
            seen         = 0;
            inflight     = 0;
            last_rsp_cyc = cyc;
          end
        end
      end
      if (req_valid && req_ready) begin
        exp_t e;
        if (b2b_arm) begin
          chk("b2b_accept", cyc, last_rsp_cyc + 1);
          b2b_arm = 0;
        end
        e.rd  = req_rd;
        e.acc = cyc;
        e.a   = req_rs1;
        e.b   = req_rs2;
        if (req_funct3[2]) begin
          e.err = 1'b1; e.data = '0; e.lat = 1; e.en = 0;
        end else begin
          e.en  = 1;
          e.err = (req_mode == 2) || (req_lat > int'(TIMEOUT));
          e.data = e.err ? 32'h0 : ref_mul(req_funct3, req_rs1, req_rs2);
          e.lat  = e.err ? int'(TIMEOUT) + 2 : 3 + req_lat;
        end
        sb.push_back(e);
        inflight = 1;
        en_cnt   = 0;
        cur_lat  = req_lat;
        cur_mode = req_mode;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the handshake.
  task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [RD_W-1:0] rd, input int lat, input int mode);
    bit ok = 0;
    req_funct3 = f; req_rs1 = a; req_rs2 = b; req_rd = rd;
    req_lat = lat; req_mode = mode; req_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_ready && rst_n) begin ok = 1; break; end
    end
    if (!ok) chk("req_accept_timeout", 0, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !inflight) begin ok = 1; break; end
    end
    if (!ok) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mul_en"}, mul_en, 0);
    chk({tag, "_mul_a"}, mul_a, 0);
    chk({tag, "_mul_b"}, mul_b, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_rd"}, rsp_rd, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(3'b000, 32'd15, 32'hFFFF_FFFC, 5'h13, 2, 0); drain();
    send(3'b001, 32'h8000_0000, 32'h8000_0000, 5'h02, 2, 1); drain();
    send(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h03, 2, 1); drain();
    send(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h04, 2, 1); drain();

    rdy_mode = 2;
    fork
      begin
        send(3'b000, 32'd7, 32'd6, 5'h07, 2, 0);
        b2b_arm = 1;
        send(3'b000, 32'd9, 32'hFFFF_FFF7, 5'h08, 2, 0);
      end
      begin
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (rsp_valid) break;
        end
        repeat (3) @(posedge clk);
        #1 rdy_mode = 1;
      end
    join
    drain();

    send(3'b100, 32'd5, 32'd5, 5'h11, 2, 0); drain();
    send(3'b111, 32'd5, 32'd5, 5'h12, 2, 0); drain();
    send(3'b000, 32'd5, 32'd5, 5'h13, 2, 2); drain();
    send(3'b011, 32'hDEAD_BEEF, 32'h8765_4321, 5'h14, int'(TIMEOUT), 1); drain();
    send(3'b011, 32'hDEAD_BEEF, 32'h8765_4321, 5'h15, int'(TIMEOUT) + 1, 0); drain();

    send(3'b000, 32'd100, 32'd100, 5'h16, 10, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midop_reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(3'b000, 32'd3, 32'd5, 5'h17, 2, 0); drain();

    rdy_mode = 0;
    for (int n = 0; n < 150; n++) begin
      logic [2:0] f;
      int         r, lat, mode;
      f = ($urandom % 8 == 0) ? 3'(4 + $urandom % 4) : 3'($urandom % 4);
      r = $urandom % 20;
      if (r < 14) begin
        lat = 1 + $urandom % 4; mode = $urandom % 2;
      end else if (r < 18) begin
        lat = int'(TIMEOUT) - 1 + $urandom % 3; mode = $urandom % 2;
      end else begin
        lat = 2; mode = 2;
      end
      send(f, pick(), pick(), RD_W'($urandom), lat, mode);
      if ($urandom % 4 == 0) begin
        repeat (1 + $urandom % 3) @(posedge clk);
        #1;
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
